// File: rtl/burst_serializer.sv
// Collects BURST_LEN bytes, then sends them plus their mod-256 checksum as
// back-to-back async-serial frames: start, d0..d7, optional even parity, stop.
module burst_serializer #(
  parameter int BURST_LEN = 8,
  parameter int BIT_DIV   = 4,
  parameter int PARITY_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       burst_done,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W      = $clog2(BURST_LEN + 1);
  localparam int IDX_W      = $clog2(BURST_LEN);
  localparam int DIV_W      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int FRAME_BITS = 10 + PARITY_EN;

  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BURST_LEN);
  localparam logic [DIV_W-1:0] LAST_DIV   = DIV_W'(BIT_DIV - 1);
  localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TX   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_buf [BURST_LEN];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frame;
  logic [3:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_csum;
  logic             r_tx;
  logic             r_done;

  logic       w_accept;
  logic       w_last_accept;
  logic       w_bit_end;
  logic       w_frame_end;
  logic       w_burst_end;
  logic [7:0] w_cur_byte;
  logic [3:0] w_next_idx;
  logic       w_next_bit;

  // Bit idx of a frame carrying byte d: 0 start, 1..8 data, then parity/stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic b;
    if (idx == 4'd0)                             b = 1'b0;
    else if (idx <= 4'd8)                        b = d[3'(idx - 4'd1)];
    else if ((PARITY_EN != 0) && (idx == 4'd9))  b = ^d;
    else                                         b = 1'b1;
    return b;
  endfunction

  // Valid/ready: a byte transfers on a rising edge with in_valid && in_ready;
  // in_ready is a pure state decode and never depends on in_valid.
  assign w_accept      = in_valid && in_ready;
  assign w_last_accept = w_accept && (r_cnt == LAST_BYTE);
  assign w_bit_end     = (r_div == LAST_DIV);
  assign w_frame_end   = w_bit_end && (r_bit == LAST_BIT);
  assign w_burst_end   = w_frame_end && (r_frame == LAST_FRAME);
  assign w_cur_byte    = (r_frame == LAST_FRAME) ? r_csum : r_buf[r_frame[IDX_W-1:0]];
  assign w_next_idx    = r_bit + 4'd1;
  assign w_next_bit    = frame_bit(w_cur_byte, w_next_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = LOAD;
      LOAD:    if (w_last_accept) w_next_state = TX;
      TX:      if (w_burst_end) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == LOAD);
    busy        = (r_state == TX);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_cnt[IDX_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_frame <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_csum  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_csum <= '0;
        end
        LOAD: begin
          if (w_accept) begin
            r_csum <= r_csum + in_data;
            // The last byte's edge also launches the first start bit.
            if (w_last_accept) begin
              r_cnt   <= '0;
              r_frame <= '0;
              r_bit   <= '0;
              r_div   <= '0;
              r_tx    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        TX: begin
          if (!w_bit_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (w_burst_end) begin
              r_frame <= '0;
              r_bit   <= '0;
              r_csum  <= '0;
              r_tx    <= 1'b1;
              r_done  <= 1'b1;
            end else if (w_frame_end) begin
              r_bit   <= '0;
              r_frame <= r_frame + 1'b1;
              r_tx    <= 1'b0;
            end else begin
              r_bit <= w_next_idx;
              r_tx  <= w_next_bit;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx         = r_tx;
  assign burst_done = r_done;

endmodule

// File: tb/tb_burst_serializer.sv
// Scoreboard bench for burst_serializer: default configuration (unit 0) and
// the BIT_DIV=1 / no-parity / BURST_LEN=2 corner (unit 1).
module tb_burst_serializer;

  localparam int BL0 = 8, BD0 = 4, PE0 = 1;
  localparam int BL1 = 2, BD1 = 1, PE1 = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_v;
  logic [7:0] in_data [2];
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] burst_done;
  logic [1:0] dbg0, dbg1;

  burst_serializer #(.BURST_LEN(BL0), .BIT_DIV(BD0), .PARITY_EN(PE0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]),
    .burst_done(burst_done[0]), .o_dbg_state(dbg0));

  burst_serializer #(.BURST_LEN(BL1), .BIT_DIV(BD1), .PARITY_EN(PE1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]),
    .burst_done(burst_done[1]), .o_dbg_state(dbg1));

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // reference model
  function automatic int bl(input int u);  return (u == 0) ? BL0 : BL1; endfunction
  function automatic int bd(input int u);  return (u == 0) ? BD0 : BD1; endfunction
  function automatic int pe(input int u);  return (u == 0) ? PE0 : PE1; endfunction
  function automatic int flen(input int u); return (10 + pe(u)) * bd(u); endfunction
  function automatic int tot(input int u);  return (bl(u) + 1) * flen(u); endfunction

  // Expected tx samples of one frame, one sample per clock, sample 0 = first start cycle.
  function automatic logic [63:0] frame_samples(input int u, input logic [7:0] b);
    logic [63:0] s;
    logic [10:0] seq;
    int nb;
    s = '0;
    if (pe(u) != 0) begin seq = {1'b1, ^b, b, 1'b0}; nb = 11; end
    else begin seq = {1'b0, 1'b1, b, 1'b0}; nb = 10; end
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < bd(u); k++) s[i * bd(u) + k] = seq[i];
    return s;
  endfunction

  logic [63:0] exp_q0[$], exp_q1[$];
  int          done_q0[$], done_q1[$];
  logic [7:0]  acc_q0[$], acc_q1[$];

  // Called at the negedge before the accepting edge, so cyc + 1 is that edge.
  task automatic model_accept(input int u, input logic [7:0] b);
    logic [7:0] sum;
    sum = 8'd0;
    if (u == 0) begin
      acc_q0.push_back(b);
      if (acc_q0.size() == BL0) begin
        foreach (acc_q0[i]) begin
          exp_q0.push_back(frame_samples(0, acc_q0[i]));
          sum += acc_q0[i];
        end
        exp_q0.push_back(frame_samples(0, sum));
        done_q0.push_back(cyc + 1 + tot(0));
        acc_q0.delete();
      end
    end else begin
      acc_q1.push_back(b);
      if (acc_q1.size() == BL1) begin
        foreach (acc_q1[i]) begin
          exp_q1.push_back(frame_samples(1, acc_q1[i]));
          sum += acc_q1[i];
        end
        exp_q1.push_back(frame_samples(1, sum));
        done_q1.push_back(cyc + 1 + tot(1));
        acc_q1.delete();
      end
    end
  endtask

  // monitor / scoreboard
  bit          mon_act [2];
  logic [63:0] mon_s   [2];
  int          mon_n   [2];

  always @(negedge clk) begin
    logic [63:0] e;
    int          ed;
    for (int u = 0; u < 2; u++) begin
      if (rst_v[u] !== 1'b1) begin
        mon_act[u] = 1'b0;
      end else begin
        if (busy[u] !== 1'b1) check("idle_high", 64'(tx[u]), 64'd1);
        if (!mon_act[u]) begin
          if (tx[u] === 1'b0) begin
            mon_act[u] = 1'b1;
            mon_s[u]   = '0;
            mon_n[u]   = 1;
          end
        end else begin
          mon_s[u][mon_n[u]] = tx[u];
          mon_n[u]++;
        end
        if (mon_act[u] && mon_n[u] == flen(u)) begin
          mon_act[u] = 1'b0;
          e = '1;
          if (u == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
          if (u == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
          check((u == 0) ? "frame_u0" : "frame_u1", mon_s[u], e);
        end
        if (burst_done[u] === 1'b1) begin
          ed = -1;
          if (u == 0 && done_q0.size() > 0) ed = done_q0.pop_front();
          if (u == 1 && done_q1.size() > 0) ed = done_q1.pop_front();
          check((u == 0) ? "done_cycle_u0" : "done_cycle_u1", 64'(cyc), 64'(ed));
          check("ready_at_done", 64'(in_ready[u]), 64'd1);
          check("busy_at_done", 64'(busy[u]), 64'd0);
        end
      end
    end
  end

  // driver tasks
  logic [7:0] pat [16];

  task automatic put_byte(input int u, input logic [7:0] b, output int acc);
    int t;
    t = 0;
    in_data[u]  = b;
    in_valid[u] = 1'b1;
    while (in_ready[u] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 64'(in_ready[u]), 64'd1);
    acc = cyc + 1;
    if (in_ready[u] === 1'b1) model_accept(u, b);
    @(negedge clk);
  endtask

  task automatic send_burst(input int u, input int max_gap, input bit hold,
                            input logic [7:0] hold_val, output int first_acc, output int last_acc);
    int g;
    first_acc = 0;
    last_acc  = 0;
    for (int i = 0; i < bl(u); i++) begin
      if (i > 0 && max_gap > 0) begin
        g = int'($urandom_range(max_gap, 0));
        if (g > 0) begin
          in_valid[u] = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      put_byte(u, pat[i], last_acc);
      if (i == 0) first_acc = last_acc;
    end
    check("ready_low_after_last", 64'(in_ready[u]), 64'd0);
    check("busy_after_last", 64'(busy[u]), 64'd1);
    in_valid[u] = hold;
    in_data[u]  = hold_val;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
  endtask

  task automatic drain(input int u);
    int t, left;
    t = 0;
    left = (u == 0) ? exp_q0.size() + done_q0.size() : exp_q1.size() + done_q1.size();
    while (left != 0 && t < 3000) begin
      @(negedge clk);
      t++;
      left = (u == 0) ? exp_q0.size() + done_q0.size() : exp_q1.size() + done_q1.size();
    end
    check("drain", 64'(left), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, la, prev_la;
    logic [7:0] nh;
    rst_v      = 2'b00;
    in_valid   = 2'b00;
    in_data[0] = 8'd0;
    in_data[1] = 8'd0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_tx", 64'(tx[u]), 64'd1);
      check("rst_busy", 64'(busy[u]), 64'd0);
      check("rst_done", 64'(burst_done[u]), 64'd0);
      check("rst_ready", 64'(in_ready[u]), 64'd0);
    end
    rst_v = 2'b11;
    #1 check("ready_idle_after_release", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    check("ready_load_after_release", 64'(in_ready[0]), 64'd1);

    // basic burst 0x01..0x08
    for (int i = 0; i < 8; i++) pat[i] = 8'(i + 1);
    send_burst(0, 0, 1'b0, 8'h00, fa, la);

    // checksum wrap
    for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
    send_burst(0, 0, 1'b0, 8'h00, fa, la);

    // gapped input, then 0xAA held through TX
    fill_rand();
    send_burst(0, 3, 1'b1, 8'hAA, fa, la);
    prev_la = la;
    nh = 8'hAA;

    // back-to-back bursts, in_valid never drops
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      pat[0] = nh;
      nh = 8'($urandom);
      send_burst(0, 0, 1'b1, nh, fa, la);
      check("b2b_first_accept", 64'(fa), 64'(prev_la + tot(0) + 1));
      prev_la = la;
    end
    in_valid[0] = 1'b0;
    drain(0);

    // reset during d3 of frame 4
    fill_rand();
    pat[4] = pat[4] & 8'hF7;
    send_burst(0, 0, 1'b0, 8'h00, fa, la);
    repeat (4 * 44 + 4 * 4 + 1) @(negedge clk);
    check("tx_d3_before_reset", 64'(tx[0]), 64'd0);
    #1 rst_v[0] = 1'b0;
    exp_q0.delete();
    done_q0.delete();
    acc_q0.delete();
    #1;
    check("async_rst_tx", 64'(tx[0]), 64'd1);
    check("async_rst_busy", 64'(busy[0]), 64'd0);
    check("async_rst_done", 64'(burst_done[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    #1 check("ready_idle_after_midrst", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    check("ready_load_after_midrst", 64'(in_ready[0]), 64'd1);
    for (int i = 0; i < 8; i++) pat[i] = 8'(8'h10 + i);
    send_burst(0, 0, 1'b0, 8'h00, fa, la);
    drain(0);

    // corner configuration
    pat[0] = 8'h80;
    pat[1] = 8'h80;
    send_burst(1, 0, 1'b0, 8'h00, fa, la);
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      send_burst(1, 2, 1'b0, 8'h00, fa, la);
    end
    drain(1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
